// File: rtl/cext_fetch_aligner_pkg.sv
// cext_fetch_aligner_pkg: shared types and constants for the C-extension fetch aligner.
package cext_fetch_aligner_pkg;

    localparam int          CEXT_XLEN      = 32;
    localparam logic [31:0] CEXT_INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HI_REQ,
        ST_HI_WAIT,
        ST_HI_DONE
    } type_cext_align_state_e;

    typedef struct packed {
        logic [31:0]          instr;
        logic                 is_comp;
        logic [CEXT_XLEN-1:0] pc_aligned;
        logic                 stall;
        logic                 icache_req;
        logic                 icache_req_kill;
        logic                 icache_flush;
        logic                 addr_override;
    } type_cext2if_s;

    typedef struct packed {
        logic [31:0] instr_un;
        logic        ack;
    } type_if2cext_s;

    function automatic logic is_compressed(input logic [15:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/cext_fetch_aligner_if.sv
// cext_fetch_aligner_if: fetch <-> aligner signal bundle; slave is the aligner side.
interface cext_fetch_aligner_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc;
    logic [31:0]     word;
    logic            icache_ack;
    logic            redirect;
    logic            pipe_stall;
    logic [31:0]     instr;
    logic            is_comp;
    logic [XLEN-1:0] pc_aligned;
    logic            stall;
    logic            icache_req;
    logic            addr_override;
    logic [XLEN-1:0] fetch_addr;
    logic            icache_req_kill;

    modport slave (
        input  pc, word, icache_ack, redirect, pipe_stall,
        output instr, is_comp, pc_aligned, stall, icache_req, addr_override, fetch_addr, icache_req_kill
    );

    modport master (
        output pc, word, icache_ack, redirect, pipe_stall,
        input  instr, is_comp, pc_aligned, stall, icache_req, addr_override, fetch_addr, icache_req_kill
    );
endinterface

// File: rtl/cext_fetch_aligner_parcel_sel.sv
// cext_parcel_sel: picks the 16-bit parcel at the PC and classifies it.
module cext_parcel_sel
    import cext_fetch_aligner_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_pc_lo,
    output logic [15:0] o_parcel,
    output logic        o_comp_raw,
    output logic        o_is_comp
);
    assign o_parcel   = i_pc_lo[1] ? i_word[31:16] : i_word[15:0];
    assign o_comp_raw = is_compressed(o_parcel);
    // a misaligned PC is never reported as compressed; fetch raises the fault
    assign o_is_comp  = o_comp_raw && !i_pc_lo[0];
endmodule

// File: rtl/cext_fetch_aligner.sv
// cext_fetch_aligner: aligns 16/32-bit parcels out of fetched words and
// sequences a second icache access for 32-bit instructions that straddle a word.
module cext_fetch_aligner
    import cext_fetch_aligner_pkg::*;
#(
    parameter int          XLEN      = CEXT_XLEN,
    parameter logic [31:0] INSTR_NOP = CEXT_INSTR_NOP
)(
    input logic                clk,
    input logic                rst_n,
    cext_fetch_aligner_if.slave fetch_if
);
    type_cext_align_state_e r_state, w_state_nxt;
    logic [15:0]     r_hold_lo, r_hold_hi;
    logic [XLEN-1:0] r_hold_pc;
    logic [15:0]     w_parcel;
    logic            w_comp_raw, w_is_comp_p;
    logic            w_straddle, w_run_mode;
    logic [XLEN-3:0] w_word_idx;
    logic [31:0]     w_instr;
    logic [XLEN-1:0] w_pc_aligned;
    logic            w_is_comp, w_stall, w_req, w_override, w_latch_lo, w_latch_hi;

    cext_parcel_sel u_parcel_sel (
        .i_word     (fetch_if.word),
        .i_pc_lo    (fetch_if.pc[1:0]),
        .o_parcel   (w_parcel),
        .o_comp_raw (w_comp_raw),
        .o_is_comp  (w_is_comp_p)
    );

    assign w_straddle = fetch_if.icache_ack && fetch_if.pc[1] && !w_comp_raw;
    // a redirect makes every state behave as RUN for this cycle
    assign w_run_mode = fetch_if.redirect || (r_state == ST_RUN);
    assign w_word_idx = r_hold_pc[XLEN-1:2] + {{(XLEN-3){1'b0}}, 1'b1};

    always_comb begin
        w_state_nxt  = r_state;
        w_instr      = INSTR_NOP;
        w_is_comp    = 1'b0;
        w_pc_aligned = r_hold_pc;
        w_stall      = 1'b0;
        w_req        = 1'b0;
        w_override   = 1'b0;
        w_latch_lo   = 1'b0;
        w_latch_hi   = 1'b0;
        if (w_run_mode) begin
            w_pc_aligned = fetch_if.pc;
            w_stall      = w_straddle;
            w_latch_lo   = w_straddle;
            w_instr      = (fetch_if.icache_ack && !w_straddle)
                         ? (w_comp_raw ? {16'h0000, w_parcel} : fetch_if.word) : INSTR_NOP;
            w_is_comp    = fetch_if.icache_ack && w_is_comp_p;
            w_state_nxt  = (w_straddle && !fetch_if.redirect && !fetch_if.pipe_stall) ? ST_HI_REQ : ST_RUN;
        end else if (r_state == ST_HI_REQ) begin
            w_req        = 1'b1;
            w_override   = 1'b1;
            w_stall      = 1'b1;
            w_state_nxt  = ST_HI_WAIT;
        end else if (r_state == ST_HI_WAIT) begin
            w_override   = 1'b1;
            w_instr      = fetch_if.icache_ack ? {fetch_if.word[15:0], r_hold_lo} : INSTR_NOP;
            w_stall      = !fetch_if.icache_ack || fetch_if.pipe_stall;
            w_latch_hi   = fetch_if.icache_ack && fetch_if.pipe_stall;
            w_state_nxt  = !fetch_if.icache_ack ? ST_HI_WAIT : (fetch_if.pipe_stall ? ST_HI_DONE : ST_RUN);
        end else begin
            w_instr      = {r_hold_hi, r_hold_lo};
            w_stall      = fetch_if.pipe_stall;
            w_state_nxt  = fetch_if.pipe_stall ? ST_HI_DONE : ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_hold_lo <= '0;
            r_hold_hi <= '0;
            r_hold_pc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold_lo <= w_latch_lo ? fetch_if.word[31:16] : r_hold_lo;
            r_hold_pc <= w_latch_lo ? fetch_if.pc : r_hold_pc;
            r_hold_hi <= w_latch_hi ? fetch_if.word[15:0] : r_hold_hi;
        end
    end

    assign fetch_if.instr           = w_instr;
    assign fetch_if.is_comp         = w_is_comp;
    assign fetch_if.pc_aligned      = w_pc_aligned;
    assign fetch_if.stall           = w_stall;
    assign fetch_if.icache_req      = w_req;
    assign fetch_if.addr_override   = w_override;
    assign fetch_if.fetch_addr      = {w_word_idx, 2'b00};
    assign fetch_if.icache_req_kill = fetch_if.redirect && (r_state == ST_HI_REQ || r_state == ST_HI_WAIT);
endmodule

// File: tb/tb_cext_fetch_aligner.sv
// tb_cext_fetch_aligner: scenario tasks with a transaction-level reference model
// of parcel selection and the straddle sequence, driven by directed and random stimulus.
module tb_cext_fetch_aligner;
    import cext_fetch_aligner_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cext_fetch_aligner_if #(.XLEN(32)) bus ();

    cext_fetch_aligner dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fetch_if (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [3:0] ctl();
        return {bus.stall, bus.icache_req, bus.addr_override, bus.icache_req_kill};
    endfunction

    // reference: what a RUN-state fetch of one word yields, straight from the parcel rules
    function automatic void ref_run(input logic [31:0] pc, input logic [31:0] w, input logic ack,
                                    output logic [31:0] instr, output logic comp, output logic strad);
        logic [15:0] p;
        p     = pc[1] ? w[31:16] : w[15:0];
        strad = ack && pc[1] && (p[1:0] == 2'b11);
        comp  = ack && (p[1:0] != 2'b11) && !pc[0];
        if (!ack || strad) instr = CEXT_INSTR_NOP;
        else if (p[1:0] != 2'b11) instr = {16'h0000, p};
        else instr = w;
    endfunction

    task automatic set_in(input logic [31:0] pc, input logic [31:0] w, input logic ack,
                          input logic redir, input logic pstall);
        bus.pc = pc; bus.word = w; bus.icache_ack = ack; bus.redirect = redir; bus.pipe_stall = pstall;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(32'h1000, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        checks++; if (ctl() !== 4'b0000) begin errors++; $display("FAIL reset_ctl got %b exp 0000", ctl()); end
        checks++; if (bus.instr !== CEXT_INSTR_NOP || bus.is_comp !== 1'b0) begin errors++; $display("FAIL reset_instr got %h/%b exp %h/0", bus.instr, bus.is_comp, CEXT_INSTR_NOP); end
        checks++; if (bus.fetch_addr !== 32'h4) begin errors++; $display("FAIL reset_fetch_addr got %h exp 00000004", bus.fetch_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic check_run(input logic [31:0] pc, input logic [31:0] w, input logic ack, input string tag);
        logic [31:0] ei;
        logic        ec, es;
        ref_run(pc, w, ack, ei, ec, es);
        set_in(pc, w, ack, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.instr !== ei || bus.is_comp !== ec || bus.pc_aligned !== pc || ctl() !== 4'b0000) begin
            errors++;
            $display("FAIL %s got instr=%h comp=%b pc=%h ctl=%b exp instr=%h comp=%b pc=%h ctl=0000",
                     tag, bus.instr, bus.is_comp, bus.pc_aligned, ctl(), ei, ec, pc);
        end
        next_cycle();
    endtask

    task automatic test_run_directed();
        check_run(32'h1000, 32'h0000_4501, 1'b1, "run_cli_lo");
        checks++; if (32'h0000_4501 !== 32'h0000_4501 && bus.instr === 32'h0) errors++;
        check_run(32'h1002, 32'h4501_0000, 1'b1, "run_cli_hi");
        check_run(32'h1000, 32'h00A0_0093, 1'b1, "run_addi_full");
        check_run(32'h1004, 32'h00A0_0093, 1'b0, "run_no_ack");
    endtask

    task automatic test_straddle(input logic [31:0] pc, input logic [31:0] w1, input logic [31:0] w2,
                                 input int waits, input int stalls, input string tag);
        logic [31:0] efa, ei;
        efa = (pc & 32'hFFFF_FFFC) + 32'd4;
        ei  = {w2[15:0], w1[31:16]};
        set_in(pc, w1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ctl() !== 4'b1000 || bus.instr !== CEXT_INSTR_NOP) begin errors++; $display("FAIL %s_detect got ctl=%b instr=%h exp ctl=1000 instr=%h", tag, ctl(), bus.instr, CEXT_INSTR_NOP); end
        next_cycle();
        set_in(pc, $urandom, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ctl() !== 4'b1110 || bus.fetch_addr !== efa) begin errors++; $display("FAIL %s_req got ctl=%b addr=%h exp ctl=1110 addr=%h", tag, ctl(), bus.fetch_addr, efa); end
        next_cycle();
        for (int i = 0; i < waits; i++) begin
            set_in(pc, $urandom, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checks++; if (ctl() !== 4'b1010 || bus.fetch_addr !== efa) begin errors++; $display("FAIL %s_wait got ctl=%b addr=%h exp ctl=1010 addr=%h", tag, ctl(), bus.fetch_addr, efa); end
            next_cycle();
        end
        set_in(pc, w2, 1'b1, 1'b0, stalls > 0);
        @(negedge clk);
        checks++;
        if (bus.instr !== ei || bus.is_comp !== 1'b0 || bus.pc_aligned !== pc || ctl() !== {stalls > 0, 3'b010}) begin
            errors++;
            $display("FAIL %s_ack got instr=%h comp=%b pc=%h ctl=%b exp instr=%h comp=0 pc=%h ctl=%b",
                     tag, bus.instr, bus.is_comp, bus.pc_aligned, ctl(), ei, pc, {stalls > 0, 3'b010});
        end
        next_cycle();
        for (int i = 0; i < stalls; i++) begin
            set_in(pc, $urandom, 1'b0, 1'b0, (i < stalls - 1));
            @(negedge clk);
            checks++;
            if (bus.instr !== ei || bus.pc_aligned !== pc || ctl() !== {i < stalls - 1, 3'b000}) begin
                errors++;
                $display("FAIL %s_done got instr=%h pc=%h ctl=%b exp instr=%h pc=%h ctl=%b",
                         tag, bus.instr, bus.pc_aligned, ctl(), ei, pc, {i < stalls - 1, 3'b000});
            end
            next_cycle();
        end
    endtask

    task automatic test_straddle_directed();
        test_straddle(32'h1002, 32'h0093_0000, 32'hABCD_0050, 0, 0, "strad_plan");
        check_run(32'h1006, 32'h0000_0000, 1'b0, "strad_back_in_run");
        test_straddle(32'hFFFF_FFFE, 32'h1234_5678 | 32'h0003_0000, 32'h0000_5555, 2, 0, "strad_wrap");
        test_straddle(32'h2002, 32'h00B3_0000, 32'h7777_1234, 1, 4, "strad_hi_done");
        check_run(32'h2006, 32'h4501_0000, 1'b1, "after_hi_done");
    endtask

    task automatic test_redirect();
        set_in(32'h2002, 32'h0093_0000, 1'b1, 1'b0, 1'b0);
        next_cycle();
        set_in(32'h2002, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (ctl() !== 4'b0001) begin errors++; $display("FAIL redir_hi_req got ctl=%b exp 0001", ctl()); end
        next_cycle();
        set_in(32'h3000, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ctl() !== 4'b0000) begin errors++; $display("FAIL redir_req_after got ctl=%b exp 0000", ctl()); end
        next_cycle();
        set_in(32'h2002, 32'h0093_0000, 1'b1, 1'b0, 1'b0);
        next_cycle();
        set_in(32'h2002, 32'h0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        set_in(32'h3000, 32'h0000_4501, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (ctl() !== 4'b0001 || bus.instr !== 32'h0000_4501 || bus.is_comp !== 1'b1 || bus.pc_aligned !== 32'h3000) begin
            errors++;
            $display("FAIL redir_hi_wait got ctl=%b instr=%h comp=%b pc=%h exp ctl=0001 instr=00004501 comp=1 pc=00003000",
                     ctl(), bus.instr, bus.is_comp, bus.pc_aligned);
        end
        next_cycle();
        set_in(32'h3000, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ctl() !== 4'b0000) begin errors++; $display("FAIL redir_wait_after got ctl=%b exp 0000", ctl()); end
        next_cycle();
        set_in(32'h4002, 32'h0093_0000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (ctl() !== 4'b1000) begin errors++; $display("FAIL redir_run_strad got ctl=%b exp 1000", ctl()); end
        next_cycle();
        set_in(32'h5000, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ctl() !== 4'b0000) begin errors++; $display("FAIL redir_run_after got ctl=%b exp 0000", ctl()); end
        next_cycle();
    endtask

    task automatic test_pipe_stall_run();
        set_in(32'h6002, 32'h0093_0000, 1'b1, 1'b0, 1'b1);
        next_cycle();
        set_in(32'h6002, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ctl() !== 4'b0000) begin errors++; $display("FAIL pstall_no_seq got ctl=%b exp 0000", ctl()); end
        next_cycle();
        test_straddle(32'h6002, 32'h0093_0000, 32'h0000_00A5, 0, 0, "pstall_resume");
    endtask

    task automatic test_reset_mid();
        set_in(32'h7002, 32'h0093_0000, 1'b1, 1'b0, 1'b0);
        next_cycle();
        set_in(32'h7002, 32'h0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        rst_n = 1'b0;
        #2;
        checks++; if (ctl() !== 4'b0000 || bus.fetch_addr !== 32'h4) begin errors++; $display("FAIL reset_mid got ctl=%b addr=%h exp ctl=0000 addr=00000004", ctl(), bus.fetch_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        set_in(32'h7002, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ctl() !== 4'b0000) begin errors++; $display("FAIL reset_mid_after got ctl=%b exp 0000", ctl()); end
        next_cycle();
    endtask

    task automatic test_odd_pc();
        set_in(32'h1001, 32'h0000_4501, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.is_comp !== 1'b0 || bus.pc_aligned !== 32'h1001) begin errors++; $display("FAIL odd_pc got comp=%b pc=%h exp comp=0 pc=00001001", bus.is_comp, bus.pc_aligned); end
        next_cycle();
    endtask

    task automatic test_random();
        logic [31:0] pc, w, ei;
        logic        ack, ec, es;
        for (int n = 0; n < 80; n++) begin
            pc  = $urandom & 32'hFFFF_FFFE;
            w   = $urandom;
            ack = ($urandom_range(0, 3) != 0);
            ref_run(pc, w, ack, ei, ec, es);
            if (es) test_straddle(pc, w, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), "rnd_strad");
            else check_run(pc, w, ack, "rnd_run");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_run_directed();
        test_straddle_directed();
        test_redirect();
        test_pipe_stall_run();
        test_reset_mid();
        test_odd_pc();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
